// File: rtl/button_move_pkg.sv
// Shared tic-tac-toe game definitions: board layout, square encoding,
// result codes and the button front-end state encoding.
package button_move_pkg;

    localparam int unsigned BOARD_W     = 18;
    localparam int unsigned NUM_SQUARES = 9;
    localparam int unsigned SQ_W        = 4;
    localparam logic [1:0]  SQ_EMPTY    = 2'b00;

    typedef enum logic [1:0] {
        RES_NONE = 2'd0,
        RES_XWIN = 2'd1,
        RES_OWIN = 2'd2,
        RES_DRAW = 2'd3
    } result_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SELECT,
        ST_STROBE,
        ST_WAIT_DROP,
        ST_RESULT
    } state_e;

    // Square k occupies bits [2k+1:2k] of the board vector.
    function automatic logic [1:0] square_bits(input logic [BOARD_W-1:0] board,
                                               input int unsigned        sq);
        return board[2*sq +: 2];
    endfunction

    function automatic logic square_empty(input logic [BOARD_W-1:0] board,
                                          input int unsigned        sq);
        return square_bits(board, sq) == SQ_EMPTY;
    endfunction

endpackage

// File: rtl/button_move_debounce.sv
// Button conditioner: 2-flop synchronizer, stability-count debouncer and a
// registered one-cycle rising-edge pulse of the debounced level.
module debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 10000
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_btn,
    output logic o_rise
);

    localparam int unsigned    CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q, sync_d;
    logic             level_q, level_d;
    logic             prev_q, prev_d;
    logic             rise_q, rise_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        sync_d  = {sync_q[0], i_btn};
        level_d = level_q;
        cnt_d   = '0;
        // Level flips only after the synced input has disagreed for the full count.
        if (sync_q[1] != level_q) begin
            if (cnt_q == CNT_MAX) begin
                level_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        prev_d = level_q;
        rise_d = level_q & ~prev_q;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            sync_q  <= '0;
            level_q <= 1'b0;
            prev_q  <= 1'b0;
            rise_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync_q  <= sync_d;
            level_q <= level_d;
            prev_q  <= prev_d;
            rise_q  <= rise_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_rise = rise_q;

endmodule

// File: rtl/button_move.sv
// Pushbutton move-entry front end for the tic-tac-toe game FSM: cursor over
// empty squares, move commit handshake and blinking result display.
module button_move
    import button_move_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES    = 10000,
    parameter int unsigned RESULT_HOLD_CYCLES = 2000000,
    parameter int unsigned BLINK_CYCLES       = 250000
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_btn_next,
    input  logic                   i_btn_select,
    input  logic [BOARD_W-1:0]     i_board,
    input  logic [1:0]             i_result,
    input  logic                   i_result_stb,
    input  logic                   i_need_userinput,
    output logic                   o_busy,
    output logic [SQ_W-1:0]        o_move,
    output logic                   o_move_stb,
    output logic [NUM_SQUARES-1:0] o_cursor_led,
    output logic [1:0]             o_result_led
);

    localparam int unsigned HOLD_W  = (RESULT_HOLD_CYCLES > 1) ? $clog2(RESULT_HOLD_CYCLES) : 1;
    localparam int unsigned BLINK_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [HOLD_W-1:0]  HOLD_LOAD = HOLD_W'(RESULT_HOLD_CYCLES - 1);
    localparam logic [BLINK_W-1:0] BLINK_MAX = BLINK_W'(BLINK_CYCLES - 1);

    logic next_evt, select_evt;

    debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_next (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_btn   (i_btn_next),
        .o_rise  (next_evt)
    );

    debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_select (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_btn   (i_btn_select),
        .o_rise  (select_evt)
    );

    state_e                 state_q, state_d;
    logic [SQ_W-1:0]        cursor_q, cursor_d;
    logic [SQ_W-1:0]        move_q, move_d;
    logic                   move_stb_q, move_stb_d;
    logic                   busy_q, busy_d;
    logic [NUM_SQUARES-1:0] cursor_led_q, cursor_led_d;
    logic [1:0]             result_led_q, result_led_d;
    result_e                result_q, result_d;
    logic [HOLD_W-1:0]      hold_q, hold_d;
    logic [BLINK_W-1:0]     blink_cnt_q, blink_cnt_d;
    logic                   phase_q, phase_d;

    logic [SQ_W-1:0]        first_empty, next_empty;
    logic                   first_found, next_found;
    int unsigned            idx;

    always_comb begin
        first_empty = '0;
        first_found = 1'b0;
        next_empty  = cursor_q;
        next_found  = 1'b0;
        idx         = 0;
        for (int unsigned k = 0; k < NUM_SQUARES; k++) begin
            if (!first_found && square_empty(i_board, k)) begin
                first_empty = SQ_W'(k);
                first_found = 1'b1;
            end
        end
        // Walk forward from the cursor with wrap 8 -> 0; the cursor itself is never a candidate.
        for (int unsigned i = 1; i < NUM_SQUARES; i++) begin
            idx = 32'(cursor_q) + i;
            if (idx >= NUM_SQUARES) begin
                idx = idx - NUM_SQUARES;
            end
            if (!next_found && square_empty(i_board, idx)) begin
                next_empty = SQ_W'(idx);
                next_found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cursor_d    = cursor_q;
        result_d    = result_q;
        hold_d      = hold_q;
        blink_cnt_d = blink_cnt_q;
        phase_d     = phase_q;

        if (i_result_stb) begin
            result_d    = result_e'(i_result);
            hold_d      = HOLD_LOAD;
            blink_cnt_d = '0;
            phase_d     = 1'b0;
            state_d     = ST_RESULT;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (i_need_userinput) begin
                        state_d  = ST_SELECT;
                        cursor_d = first_empty;
                    end
                end
                ST_SELECT: begin
                    if (!i_need_userinput) begin
                        state_d = ST_IDLE;
                    end else if (select_evt) begin
                        if (square_empty(i_board, 32'(cursor_q))) begin
                            state_d = ST_STROBE;
                        end
                    end else if (next_evt) begin
                        cursor_d = next_empty;
                    end
                end
                ST_STROBE: begin
                    state_d = ST_WAIT_DROP;
                end
                ST_WAIT_DROP: begin
                    if (!i_need_userinput) begin
                        state_d = ST_IDLE;
                    end
                end
                ST_RESULT: begin
                    if (hold_q == '0) begin
                        state_d = ST_IDLE;
                    end else begin
                        hold_d = hold_q - HOLD_W'(1);
                        if (blink_cnt_q == BLINK_MAX) begin
                            blink_cnt_d = '0;
                            phase_d     = ~phase_q;
                        end else begin
                            blink_cnt_d = blink_cnt_q + BLINK_W'(1);
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        // Outputs are decoded from the next state so every port comes straight from a flop.
        move_stb_d   = (state_d == ST_STROBE);
        move_d       = move_stb_d ? cursor_q : move_q;
        busy_d       = (state_d == ST_RESULT);
        cursor_led_d = (state_d == ST_SELECT) ? (NUM_SQUARES'(1) << cursor_d) : '0;
        result_led_d = (busy_d && phase_d) ? result_d : 2'b00;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q      <= ST_IDLE;
            cursor_q     <= '0;
            move_q       <= '0;
            move_stb_q   <= 1'b0;
            busy_q       <= 1'b0;
            cursor_led_q <= '0;
            result_led_q <= '0;
            result_q     <= RES_NONE;
            hold_q       <= '0;
            blink_cnt_q  <= '0;
            phase_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cursor_q     <= cursor_d;
            move_q       <= move_d;
            move_stb_q   <= move_stb_d;
            busy_q       <= busy_d;
            cursor_led_q <= cursor_led_d;
            result_led_q <= result_led_d;
            result_q     <= result_d;
            hold_q       <= hold_d;
            blink_cnt_q  <= blink_cnt_d;
            phase_q      <= phase_d;
        end
    end

    assign o_busy       = busy_q;
    assign o_move       = move_q;
    assign o_move_stb   = move_stb_q;
    assign o_cursor_led = cursor_led_q;
    assign o_result_led = result_led_q;

endmodule

// File: tb/tb_button_move.sv
// Scoreboarded bench for button_move: expected moves are queued as presses are
// driven and retired by a monitor on every observed move strobe.
module tb_button_move;

    logic        clk = 1'b0;
    logic        i_reset;
    logic        i_btn_next;
    logic        i_btn_select;
    logic [17:0] i_board;
    logic [1:0]  i_result;
    logic        i_result_stb;
    logic        i_need_userinput;
    logic        o_busy;
    logic [3:0]  o_move;
    logic        o_move_stb;
    logic [8:0]  o_cursor_led;
    logic [1:0]  o_result_led;

    int          checks = 0;
    int          errors = 0;
    int          stb_count = 0;
    logic [3:0]  exp_q[$];
    logic [3:0]  mon_exp;

    always #5 clk = ~clk;

    button_move #(
        .DEBOUNCE_CYCLES    (4),
        .RESULT_HOLD_CYCLES (20),
        .BLINK_CYCLES       (5)
    ) dut (
        .i_clk            (clk),
        .i_reset          (i_reset),
        .i_btn_next       (i_btn_next),
        .i_btn_select     (i_btn_select),
        .i_board          (i_board),
        .i_result         (i_result),
        .i_result_stb     (i_result_stb),
        .i_need_userinput (i_need_userinput),
        .o_busy           (o_busy),
        .o_move           (o_move),
        .o_move_stb       (o_move_stb),
        .o_cursor_led     (o_cursor_led),
        .o_result_led     (o_result_led)
    );

    always @(negedge clk) begin
        if (o_move_stb === 1'b1) begin
            stb_count++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_strobe move=%0d required no strobe", o_move);
            end else begin
                mon_exp = exp_q.pop_front();
                if (o_move !== mon_exp) begin
                    errors++;
                    $display("FAIL move_value got=%0d exp=%0d", o_move, mon_exp);
                end
            end
            checks++;
            if (o_busy !== 1'b0) begin
                errors++;
                $display("FAIL busy_during_strobe got=%b exp=0", o_busy);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press_next();
        i_btn_next = 1'b1;
        cyc(10);
        i_btn_next = 1'b0;
        cyc(10);
    endtask

    task automatic press_select();
        i_btn_select = 1'b1;
        cyc(10);
        i_btn_select = 1'b0;
        cyc(10);
    endtask

    task automatic check_outputs_zero(input string name);
        checks++;
        if ({o_busy, o_move, o_move_stb, o_cursor_led, o_result_led} !== 18'd0) begin
            errors++;
            $display("FAIL %s got busy=%b move=%0d stb=%b cur=%b res=%0d exp all 0",
                     name, o_busy, o_move, o_move_stb, o_cursor_led, o_result_led);
        end
    endtask

    task automatic check_cursor(input string name, input logic [8:0] exp);
        checks++;
        if (o_cursor_led !== exp) begin
            errors++;
            $display("FAIL %s got=%b exp=%b", name, o_cursor_led, exp);
        end
    endtask

    task automatic check_stb_count(input string name, input int exp);
        checks++;
        if (stb_count !== exp) begin
            errors++;
            $display("FAIL %s strobes got=%0d exp=%0d", name, stb_count, exp);
        end
    endtask

    task automatic test_reset();
        i_reset = 1'b1;
        i_btn_next = 1'b0;
        i_btn_select = 1'b0;
        i_board = '0;
        i_result = '0;
        i_result_stb = 1'b0;
        i_need_userinput = 1'b0;
        #12;
        check_outputs_zero("reset_outputs");
        cyc(2);
        i_reset = 1'b0;
        cyc(3);
        check_outputs_zero("post_reset_idle");
    endtask

    task automatic test_basic_commit();
        int base;
        i_board = '0;
        i_need_userinput = 1'b1;
        cyc(3);
        check_cursor("basic_cursor_init", 9'b000000001);
        base = stb_count;
        exp_q.push_back(4'd0);
        i_btn_select = 1'b1;
        cyc(10);
        i_btn_select = 1'b0;
        cyc(10);
        check_stb_count("basic_one_strobe", base + 1);
        check_cursor("basic_cursor_after_commit", 9'b0);
        i_need_userinput = 1'b0;
        cyc(3);
    endtask

    task automatic test_skip_occupied();
        logic [17:0] b;
        int base;
        b = '0;
        b[1:0] = 2'b01;
        b[3:2] = 2'b10;
        b[9:8] = 2'b01;
        i_board = b;
        i_need_userinput = 1'b1;
        cyc(3);
        check_cursor("skip_cursor_init", 9'b000000100);
        press_next();
        check_cursor("skip_cursor_next1", 9'b000001000);
        press_next();
        check_cursor("skip_cursor_next2", 9'b000100000);
        base = stb_count;
        exp_q.push_back(4'd5);
        press_select();
        check_stb_count("skip_one_strobe", base + 1);
        cyc(5);
        checks++;
        if (o_move !== 4'd5) begin
            errors++;
            $display("FAIL move_hold got=%0d exp=5", o_move);
        end
        i_need_userinput = 1'b0;
        cyc(3);
    endtask

    task automatic test_wrap_glitch();
        int base;
        i_board = {2'b00, {8{2'b01}}};
        i_need_userinput = 1'b1;
        cyc(3);
        check_cursor("wrap_cursor_init", 9'b100000000);
        press_next();
        check_cursor("wrap_cursor_stays", 9'b100000000);
        base = stb_count;
        i_btn_select = 1'b1;
        cyc(2);
        i_btn_select = 1'b0;
        cyc(15);
        check_stb_count("glitch_no_strobe", base);
        check_cursor("glitch_still_select", 9'b100000000);
        i_need_userinput = 1'b0;
        cyc(3);
    endtask

    task automatic test_back_to_back();
        int base;
        i_board = '0;
        i_need_userinput = 1'b1;
        cyc(3);
        base = stb_count;
        exp_q.push_back(4'd0);
        press_select();
        check_stb_count("b2b_first_strobe", base + 1);
        cyc(50);
        press_select();
        check_stb_count("b2b_no_double", base + 1);
        i_need_userinput = 1'b0;
        cyc(3);
        i_need_userinput = 1'b1;
        cyc(3);
        exp_q.push_back(4'd0);
        press_select();
        check_stb_count("b2b_second_after_drop", base + 2);
        i_need_userinput = 1'b0;
        cyc(3);
    endtask

    task automatic test_result_display();
        logic [1:0] exp_led;
        i_result = 2'd3;
        i_result_stb = 1'b1;
        @(posedge clk);
        #1;
        i_result_stb = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            exp_led = (((k / 5) % 2) == 1) ? 2'd3 : 2'd0;
            checks++;
            if (o_busy !== 1'b1) begin
                errors++;
                $display("FAIL result_busy k=%0d got=%b exp=1", k, o_busy);
            end
            checks++;
            if (o_result_led !== exp_led) begin
                errors++;
                $display("FAIL result_led k=%0d got=%0d exp=%0d", k, o_result_led, exp_led);
            end
        end
        @(negedge clk);
        checks++;
        if (o_busy !== 1'b0 || o_result_led !== 2'd0) begin
            errors++;
            $display("FAIL result_end got busy=%b led=%0d exp busy=0 led=0", o_busy, o_result_led);
        end
        cyc(2);
    endtask

    task automatic test_priority_reset();
        int base;
        i_board = '0;
        i_need_userinput = 1'b1;
        cyc(3);
        base = stb_count;
        i_btn_select = 1'b1;
        cyc(4);
        // Result strobe window straddles the debounced select event.
        i_result = 2'd1;
        i_result_stb = 1'b1;
        cyc(6);
        i_result_stb = 1'b0;
        i_btn_select = 1'b0;
        checks++;
        if (o_busy !== 1'b1) begin
            errors++;
            $display("FAIL priority_busy got=%b exp=1", o_busy);
        end
        cyc(5);
        check_stb_count("priority_no_strobe", base);
        check_cursor("priority_cursor_off", 9'b0);
        checks++;
        if (o_busy !== 1'b1) begin
            errors++;
            $display("FAIL priority_busy_hold got=%b exp=1", o_busy);
        end
        i_reset = 1'b1;
        #1;
        check_outputs_zero("reset_mid_result");
        cyc(2);
        i_reset = 1'b0;
        cyc(3);
        check_cursor("post_reset_select", 9'b000000001);
        i_need_userinput = 1'b0;
        cyc(3);
    endtask

    initial begin
        test_reset();
        test_basic_commit();
        test_skip_occupied();
        test_wrap_glitch();
        test_back_to_back();
        test_result_display();
        test_priority_reset();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_strobes got=%0d pending exp=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/button_move.md
# button_move

Pushbutton move-entry front end for the tic-tac-toe game FSM. It is an alternative to the UART user module and implements the same game-side handshake: `need_userinput` in; move, strobe and busy out; result strobe in. Two debounced buttons let the player walk a one-hot cursor over the empty squares and commit a move. On a game result it blinks the result LEDs and holds busy for a fixed period.

## Interface
- `DEBOUNCE_CYCLES`, default 10000: consecutive stable cycles required before a button level is accepted.
- `RESULT_HOLD_CYCLES`, default 2000000: cycles busy is held after a result.
- `BLINK_CYCLES`, default 250000: half-period of the result LED blink.
- `i_clk`  in  1: system clock; the only clock.
- `i_reset`  in  1: asynchronous, active-high reset.
- `i_btn_next`  in  1: raw, asynchronous, active-high "advance cursor" button.
- `i_btn_select`  in  1: raw, asynchronous, active-high "commit move" button.
- `i_board`  in  18: current board. Square k occupies bits [2k+1:2k]; 00 means empty.
- `i_result`  in  2: 0 NONE, 1 XWIN, 2 OWIN, 3 DRAW.
- `i_result_stb`  in  1: one-cycle result strobe.
- `i_need_userinput`  in  1: level; high while the game wants a move.
- `o_busy`  out  1: high only while showing a result.
- `o_move`  out  4: committed square index, 0..8.
- `o_move_stb`  out  1: one-cycle pulse; `o_move` is valid in the same cycle.
- `o_cursor_led`  out  9: one-hot cursor position; all zero outside SELECT.
- `o_result_led`  out  2: latched result, gated by the blink phase.

## Operation
- **Button conditioning.** Each button passes through a 2-flop synchronizer, then a debouncer. The debounced level changes only after the synced input has differed from it for `DEBOUNCE_CYCLES` consecutive cycles. A registered rising edge of the debounced level produces a one-cycle event.
- **State machine.** States are IDLE, SELECT, STROBE, WAIT_DROP and RESULT.
- **IDLE:** button events are ignored. Moves to SELECT when `i_need_userinput` is 1; the cursor is loaded with the lowest empty square, or 0 if there is none.
- **SELECT:**
  - A next event moves the cursor to the next empty square after the cursor, wrapping 8 to 0. If no other square is empty, the cursor is unchanged.
  - A select event moves to STROBE if the cursor square is empty; otherwise it is ignored.
  - If next and select events occur in the same cycle, select wins.
  - If `i_need_userinput` drops, go to IDLE.
- **STROBE:** `o_move_stb` = 1 and `o_move` = cursor, for exactly one cycle; then go to WAIT_DROP.
- **WAIT_DROP:** go to IDLE once `i_need_userinput` = 0. This prevents a double commit.
- **Result capture.** `i_result_stb` = 1 in any state has top priority:
  - latch `i_result`;
  - load the hold counter with `RESULT_HOLD_CYCLES`-1;
  - clear the blink phase;
  - go to RESULT.
- **RESULT:**
  - `o_busy` = 1.
  - `o_result_led` = latched result while the blink phase is 1, else 0. The phase toggles every `BLINK_CYCLES` cycles.
  - Counter reaching 0 returns the block to IDLE with `o_busy` = 0.
  - A new `i_result_stb` reloads the counter.
- **Output holding.** `o_move` holds its value between strobes.
- **Reset values:**
  - state IDLE; cursor 0;
  - `o_busy`, `o_move_stb`, `o_move`, `o_cursor_led`, `o_result_led` all 0;
  - debounced levels 0; counters cleared.
- **Reset mid-operation** abandons any pending move or result display.

## Timing
- Raw press to debounced event: 2 synchronizer cycles + `DEBOUNCE_CYCLES` + 1 edge cycle.
- Select event registered at edge T gives `o_move_stb` high for the cycle after T; `o_busy` is 0 in that cycle.
- `i_result_stb` sampled high at edge E gives `o_busy` = 1 from E. The game checks busy two cycles after its strobe, so busy is already high when sampled.
- `o_busy` is high for exactly `RESULT_HOLD_CYCLES` cycles after the last result strobe.
- All outputs are registered.

## Structure
- Shared game package holds:
  - result codes NONE/XWIN/OWIN/DRAW;
  - the square-to-bitpair encoding;
  - the board width (18) and square count (9).
- One sub-module, `debounce` (synchronizer, stability counter, edge pulse), instantiated once per button.
- The next-empty-square search is combinational inside `button_move`.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4, `RESULT_HOLD_CYCLES`=20, `BLINK_CYCLES`=5.

- **Basic commit.** Empty board, need=1, press select and hold it for 10 cycles → exactly one `o_move_stb` pulse with `o_move`=0; `o_cursor_led`=9'b000000001 before the commit.
- **Skip occupied.** Board has squares 0, 1, 4 occupied; need=1; press next twice, then select → cursor 2 then 3, then 5; `o_move`=5.
- **Wrap and glitch rejection.** Only square 8 is empty; press next → cursor stays 8. A 2-cycle glitch on select produces no strobe.
- **No double commit.** After a strobe, hold need=1 for 50 cycles and press select again → no second strobe; after need drops and rises, one new strobe.
- **Result display.** Pulse `i_result_stb` with `i_result`=3 → `o_busy` high from the next edge for 20 cycles; `o_result_led` alternates 3/0 every 5 cycles, starting at 0; then idle.
- **Priority and reset.**
  - `i_result_stb` in the same cycle as a select event → no move strobe; RESULT entered.
  - Assert `i_reset` mid-RESULT → all outputs 0 immediately.
